// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a CPU core and a loader; the loader preempts the core, bounded by MAX_BURST grants.
// Zero-latency mux with a one-cycle RESTORE refetch; the core is backpressured through core_stall, the loader through ld_gnt.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] core_adr,
    input  logic          core_we,
    input  logic [31:0]   core_wdata,
    output logic [31:0]   core_rdata,
    output logic          core_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {ST_CORE, ST_LOADER, ST_RESTORE} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t     state_q, state_d;
    logic [7:0] burst_q, burst_d;
    logic [8:0] burst_inc;
    logic       restored_q;
    logic       rvalid_q;
    logic       sel_ld, gnt, stall, core_we_en;

    assign burst_inc = {1'b0, burst_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        sel_ld     = 1'b0;
        gnt        = 1'b0;
        stall      = 1'b0;
        core_we_en = 1'b1;
        case (state_q)
            ST_CORE: begin
                burst_d = 8'd0;
                // The first CORE cycle after RESTORE always belongs to the core.
                if (ld_req && !restored_q) begin
                    sel_ld  = 1'b1;
                    gnt     = 1'b1;
                    stall   = 1'b1;
                    burst_d = 8'd1;
                    state_d = (MAX_B <= 8'd1) ? ST_RESTORE : ST_LOADER;
                end
            end
            ST_LOADER: begin
                sel_ld = 1'b1;
                stall  = 1'b1;
                gnt    = ld_req;
                if (ld_req) begin
                    burst_d = (burst_inc >= 9'(MAX_BURST)) ? MAX_B : burst_inc[7:0];
                    if (burst_inc >= 9'(MAX_BURST))
                        state_d = ST_RESTORE;
                end else begin
                    state_d = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                // Re-present the core address so its pending read lands; its write waits.
                stall      = 1'b1;
                core_we_en = 1'b0;
                burst_d    = 8'd0;
                state_d    = ST_CORE;
            end
            default: begin
                state_d = ST_CORE;
                burst_d = 8'd0;
            end
        endcase
        if (!reset) begin
            sel_ld     = 1'b0;
            gnt        = 1'b0;
            stall      = 1'b0;
            core_we_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CORE;
            burst_q    <= 8'd0;
            restored_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            restored_q <= (state_q == ST_RESTORE);
            rvalid_q   <= gnt & ~ld_we;
        end
    end

    assign mem_adr    = sel_ld ? ld_adr : core_adr;
    assign mem_we     = sel_ld ? (ld_we & gnt) : (core_we & core_we_en);
    assign mem_wdata  = sel_ld ? ld_wdata : core_wdata;
    assign core_rdata = mem_rdata;
    assign core_stall = stall;
    assign ld_gnt     = gnt;
    assign ld_rvalid  = rvalid_q;
    assign ld_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MAX_BURST=8 instance on a modelled memory, MAX_BURST=1 instance under stuck ld_req.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] core_adr, core_wdata, core_rdata, ld_adr, ld_wdata, ld_rdata;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        core_we, core_stall, ld_req, ld_we, ld_gnt, ld_rvalid, mem_we;

    logic [31:0] b_core_adr, b_core_wdata, b_core_rdata, b_ld_adr, b_ld_wdata, b_ld_rdata;
    logic [31:0] b_mem_adr, b_mem_wdata, b_mem_rdata;
    logic        b_core_we, b_core_stall, b_ld_req, b_ld_we, b_ld_gnt, b_ld_rvalid, b_mem_we;

    mem_port_arbiter #(.AW(32), .MAX_BURST(8)) u_dut (
        .clk(clk), .reset(reset),
        .core_adr(core_adr), .core_we(core_we), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .MAX_BURST(1)) u_dut_b1 (
        .clk(clk), .reset(reset),
        .core_adr(b_core_adr), .core_we(b_core_we), .core_wdata(b_core_wdata),
        .core_rdata(b_core_rdata), .core_stall(b_core_stall),
        .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_adr(b_ld_adr), .ld_wdata(b_ld_wdata),
        .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
        .mem_adr(b_mem_adr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Word-addressed memory with registered read; counts writes to 0x300.
    logic [31:0] mem [0:255];
    int          wr_cnt_300 = 0;
    always @(posedge clk) begin
        mem_rdata <= mem[mem_adr[9:2]];
        if (mem_we) begin
            mem[mem_adr[9:2]] <= mem_wdata;
            if (mem_adr == 32'h300) wr_cnt_300 = wr_cnt_300 + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, pk, b_grants;
        logic        pg, eg;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        reset = 1'b0;
        core_adr = 32'h0; core_we = 1'b0; core_wdata = 32'h0;
        ld_req = 1'b1; ld_we = 1'b0; ld_adr = 32'h0; ld_wdata = 32'h0;
        b_core_adr = 32'h10; b_core_we = 1'b0; b_core_wdata = 32'h0;
        b_ld_req = 1'b0; b_ld_we = 1'b0; b_ld_adr = 32'h20; b_ld_wdata = 32'h0;
        b_mem_rdata = 32'h0;

        // Reset values while ld_req is held high
        #12;
        check("rst_gnt", 32'(ld_gnt), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        ld_req = 1'b0;
        reset  = 1'b1;

        // Plain core read of 0x100
        next_cycle();
        core_adr = 32'h100;
        #3;
        check("cr_adr", mem_adr, 32'h100);
        check("cr_stall", 32'(core_stall), 32'd0);
        next_cycle(); #3;
        check("cr_rdata", core_rdata, 32'hC0DE_0040);

        // Single loader write during a core read of 0x200
        next_cycle();
        core_adr = 32'h200; ld_req = 1'b1; ld_we = 1'b1; ld_adr = 32'h40; ld_wdata = 32'hDEAD_BEEF;
        #3;
        check("lw_gnt", 32'(ld_gnt), 32'd1);
        check("lw_stall", 32'(core_stall), 32'd1);
        check("lw_adr", mem_adr, 32'h40);
        check("lw_we", 32'(mem_we), 32'd1);
        next_cycle();
        ld_req = 1'b0; ld_we = 1'b0;
        #3;
        check("lw_idle_gnt", 32'(ld_gnt), 32'd0);
        check("lw_idle_stall", 32'(core_stall), 32'd1);
        check("lw_idle_we", 32'(mem_we), 32'd0);
        next_cycle(); #3;
        check("lw_rst_stall", 32'(core_stall), 32'd1);
        check("lw_rst_adr", mem_adr, 32'h200);
        check("lw_rst_we", 32'(mem_we), 32'd0);
        next_cycle(); #3;
        check("lw_core_stall", 32'(core_stall), 32'd0);
        check("lw_core_rdata", core_rdata, 32'hC0DE_0080);
        check("lw_mem", mem[16], 32'hDEAD_BEEF);

        // Continuous loader reads 0x0..0x3C: two bursts of 8
        k = 0; pk = 0; pg = 1'b0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            ld_req = (k < 16); ld_we = 1'b0; ld_adr = 32'(k * 4);
            #3;
            eg = (c <= 7) || (c >= 10 && c <= 17);
            check($sformatf("b8_gnt_%0d", c), 32'(ld_gnt), 32'(eg));
            check($sformatf("b8_stall_%0d", c), 32'(core_stall), 32'(c <= 8 || (c >= 10 && c <= 18)));
            check($sformatf("b8_rvalid_%0d", c), 32'(ld_rvalid), 32'(pg));
            if (pg) check($sformatf("b8_rdata_%0d", c), ld_rdata, 32'hC0DE_0000 + 32'(pk));
            pg = eg; pk = k;
            if (eg) k++;
        end

        // Core write held across a loader read preemption
        next_cycle();
        core_adr = 32'h300; core_we = 1'b1; core_wdata = 32'h1234_5678;
        ld_req = 1'b1; ld_we = 1'b0; ld_adr = 32'h0;
        #3;
        check("cw_gnt", 32'(ld_gnt), 32'd1);
        check("cw_we_grant", 32'(mem_we), 32'd0);
        next_cycle();
        ld_req = 1'b0;
        #3;
        check("cw_we_loader", 32'(mem_we), 32'd0);
        next_cycle(); #3;
        check("cw_we_restore", 32'(mem_we), 32'd0);
        check("cw_adr_restore", mem_adr, 32'h300);
        check("cw_cnt_pre", 32'(wr_cnt_300), 32'd0);
        next_cycle(); #3;
        check("cw_stall_core", 32'(core_stall), 32'd0);
        check("cw_we_core", 32'(mem_we), 32'd1);
        next_cycle();
        core_we = 1'b0;
        #3;
        check("cw_cnt", 32'(wr_cnt_300), 32'd1);
        check("cw_mem", mem[192], 32'h1234_5678);

        // Reset asserted during a loader read grant
        next_cycle();
        ld_req = 1'b1; ld_we = 1'b0; ld_adr = 32'h8;
        #3;
        check("rr_gnt", 32'(ld_gnt), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rr_gnt_rst", 32'(ld_gnt), 32'd0);
        check("rr_stall_rst", 32'(core_stall), 32'd0);
        check("rr_rvalid_rst", 32'(ld_rvalid), 32'd0);
        next_cycle();
        ld_req = 1'b0;
        #3;
        check("rr_rvalid_hold", 32'(ld_rvalid), 32'd0);
        next_cycle();
        reset = 1'b1;
        #3;
        check("rr_rvalid_rel", 32'(ld_rvalid), 32'd0);
        check("rr_stall_rel", 32'(core_stall), 32'd0);
        next_cycle();
        ld_req = 1'b1;
        #3;
        check("rr_gnt_after", 32'(ld_gnt), 32'd1);
        next_cycle();
        ld_req = 1'b0;
        #3;
        check("rr_rvalid_after", 32'(ld_rvalid), 32'd1);
        check("rr_rdata_after", ld_rdata, 32'hC0DE_0002);

        // MAX_BURST=1 with ld_req stuck high: grant, RESTORE, core, repeat
        b_grants = 0;
        for (int c = 0; c < 99; c++) begin
            next_cycle();
            b_ld_req = 1'b1;
            #3;
            check($sformatf("b1_gnt_%0d", c), 32'(b_ld_gnt), 32'((c % 3) == 0));
            check($sformatf("b1_stall_%0d", c), 32'(b_core_stall), 32'((c % 3) != 2));
            if (b_ld_gnt) b_grants++;
        end
        check("b1_total", 32'(b_grants), 32'd33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
